// File: rtl/muldiv_unit_pkg.sv
// Shared ALU op codes and the multiply/divide sequencer state type.
// Imported by the ALU control decoder and by muldiv_unit.
package muldiv_unit_pkg;

  localparam logic [5:0] ALU_AND    = 6'b000000;
  localparam logic [5:0] ALU_OR     = 6'b000001;
  localparam logic [5:0] ALU_ADD    = 6'b000010;
  localparam logic [5:0] ALU_SLL    = 6'b000011;
  localparam logic [5:0] ALU_SRL    = 6'b000100;
  localparam logic [5:0] ALU_XOR    = 6'b000101;
  localparam logic [5:0] ALU_SUB    = 6'b000110;
  localparam logic [5:0] ALU_SRA    = 6'b000111;

  localparam logic [5:0] ALU_MUL    = 6'b010000;
  localparam logic [5:0] ALU_MULH   = 6'b010001;
  localparam logic [5:0] ALU_MULHSU = 6'b010010;
  localparam logic [5:0] ALU_MULHU  = 6'b010011;
  localparam logic [5:0] ALU_DIV    = 6'b010100;
  localparam logic [5:0] ALU_DIVU   = 6'b010101;
  localparam logic [5:0] ALU_REM    = 6'b010110;
  localparam logic [5:0] ALU_REMU   = 6'b010111;

  // op[5:3] value shared by every M-extension code
  localparam logic [2:0] ALU_MD_CLASS = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M-extension ops.
// Constant latency of XLEN+2 cycles from the accepting start edge to done.
//
// state | meaning
// IDLE  | waiting for start with an M-extension op
// CALC  | XLEN shift-add (mul) or restoring shift-subtract (div) steps
// FIX   | sign correction and divide special cases
// DONE  | done pulse, result valid
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int DW = 2 * XLEN;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [DW-1:0] negate(input logic [DW-1:0] v);
    return ~v + DW'(1);
  endfunction

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_r;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mb;
  logic [XLEN-1:0] ra;
  logic [XLEN-1:0] rb;
  logic [DW-1:0]   prod;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;

  logic            a_sgn;
  logic            b_sgn;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  // Operand sign handling at accept time
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      ALU_MULH, ALU_DIV, ALU_REM: begin
        a_sgn = a[XLEN-1];
        b_sgn = b[XLEN-1];
      end
      ALU_MULHSU: a_sgn = a[XLEN-1];
      default: ;
    endcase
    a_mag = a_sgn ? XLEN'(negate({{XLEN{1'b0}}, a})) : a;
    b_mag = b_sgn ? XLEN'(negate({{XLEN{1'b0}}, b})) : b;
  end

  logic [XLEN:0]   sum;
  logic [DW-1:0]   prod_nxt;
  logic [XLEN+1:0] trial;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  // One iteration step of each datapath
  always_comb begin
    sum      = {1'b0, prod[DW-1:XLEN]} + {1'b0, mb};
    prod_nxt = prod[0] ? {sum, prod[XLEN-1:1]} : {1'b0, prod[DW-1:1]};
    trial    = {rem, quo[XLEN-1]} - {2'b00, mb};
    if (trial[XLEN+1]) begin
      rem_nxt = {rem[XLEN-1:0], quo[XLEN-1]};
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = trial[XLEN:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
  end

  logic [DW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] fix_val;

  // Final value selection, consumed on the FIX edge
  always_comb begin
    prod_fix = (sa ^ sb) ? negate(prod) : prod;
    quo_fix  = (sa ^ sb) ? XLEN'(negate({{XLEN{1'b0}}, quo})) : quo;
    rem_fix  = sa ? XLEN'(negate({{XLEN{1'b0}}, rem[XLEN-1:0]})) : rem[XLEN-1:0];
    div0     = (rb == '0);
    ovf      = (ra == XMIN) && (rb == '1) && !op_r[0];
    fix_val  = '0;
    case (op_r)
      ALU_MUL[2:0]: fix_val = prod_fix[XLEN-1:0];
      ALU_MULH[2:0], ALU_MULHSU[2:0], ALU_MULHU[2:0]:
        fix_val = prod_fix[DW-1:XLEN];
      ALU_DIV[2:0], ALU_DIVU[2:0]:
        fix_val = div0 ? '1 : (ovf ? XMIN : quo_fix);
      default:
        fix_val = div0 ? ra : (ovf ? '0 : rem_fix);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mb     <= '0;
      ra     <= '0;
      rb     <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op[5:3] == ALU_MD_CLASS) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= CW'(XLEN);
            op_r  <= op[2:0];
            sa    <= a_sgn;
            sb    <= b_sgn;
            mb    <= b_mag;
            ra    <= a;
            rb    <= b;
            prod  <= {{XLEN{1'b0}}, a_mag};
            quo   <= a_mag;
            rem   <= '0;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (op_r[2]) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            prod <= prod_nxt;
          end
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          done   <= 1'b1;
          result <= fix_val;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus
// directed vectors with hand-computed results and latency checks.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int NV   = 21;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic, RISC-V M-extension semantics
  function automatic logic [31:0] model(input logic [5:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    logic signed [63:0] s_a, s_b, u_a, u_b, p;
    s_a = $signed({{32{ma[31]}}, ma});
    s_b = $signed({{32{mb[31]}}, mb});
    u_a = $signed({32'b0, ma});
    u_b = $signed({32'b0, mb});
    case (mop)
      ALU_MUL:    begin p = u_a * u_b; return p[31:0];  end
      ALU_MULH:   begin p = s_a * s_b; return p[63:32]; end
      ALU_MULHSU: begin p = s_a * u_b; return p[63:32]; end
      ALU_MULHU:  begin p = u_a * u_b; return p[63:32]; end
      ALU_DIV: begin
        if (mb == 32'h0) return 32'hFFFFFFFF;
        if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(ma) / $signed(mb);
      end
      ALU_DIVU: return (mb == 32'h0) ? 32'hFFFFFFFF : ma / mb;
      ALU_REM: begin
        if (mb == 32'h0) return ma;
        if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) return 32'h0;
        return $signed(ma) % $signed(mb);
      end
      ALU_REMU: return (mb == 32'h0) ? ma : ma % mb;
      default: return 32'h0;
    endcase
  endfunction

  // Cycle-level expectation: busy for cycles 1..XLEN+2, done and new result in XLEN+2
  int          m_cyc  = -1;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      m_cyc  <= -1;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 32'h0;
    end else if (m_cyc < 0) begin
      if (start === 1'b1 && op[5:3] == 3'b010) begin
        m_pend <= model(op, a, b);
        m_cyc  <= 0;
        m_busy <= 1'b1;
      end
    end else if (m_cyc == XLEN + 1) begin
      m_cyc  <= -1;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_done <= (m_cyc == XLEN);
      if (m_cyc == XLEN) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cmp done", {31'b0, done}, {31'b0, m_done});
      chk("cmp result", result, m_res);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [5:0]  v_op  [NV];
  logic [31:0] v_a   [NV];
  logic [31:0] v_b   [NV];
  logic [31:0] v_res [NV];

  // Called at a negedge while the unit is idle; returns at a negedge in IDLE
  task automatic run_op(input string name, input logic [5:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input logic [31:0] lit);
    int n;
    bit got;
    chk({name, " model"}, model(top, ta, tb), lit);
    start = 1'b1; op = top; a = ta; b = tb;
    @(posedge clk);
    #1;
    start = 1'b0; op = 6'($urandom); a = $urandom; b = $urandom;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({name, " busy1"}, {31'b0, busy}, 32'd1);
      if (done === 1'b1) got = 1'b1;
    end
    chk({name, " latency"}, n, XLEN + 2);
    chk({name, " result"}, result, lit);
    @(negedge clk);
  endtask

  initial begin
    v_op  = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_REM, ALU_DIVU,
              ALU_REM, ALU_DIV, ALU_REM, ALU_DIV, ALU_REMU, ALU_MULH, ALU_MULHSU,
              ALU_DIV, ALU_REM, ALU_MUL, ALU_MULHU, ALU_REMU, ALU_DIVU, ALU_REM};
    v_a   = '{32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
              32'hFFFFFFF9, 32'h00000007, 32'h00000007, 32'h80000000, 32'h80000000,
              32'h00000007, 32'h00000064, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFF9,
              32'h00000007, 32'h12345678, 32'h80000000, 32'h80000000, 32'h80000000,
              32'hFFFFFFF9};
    v_b   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002,
              32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000000, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
              32'hFFFFFFFE, 32'h00000010, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000000};
    v_res = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'h00000000,
              32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000001, 32'h00000003,
              32'h00000001, 32'h23456780, 32'h00000002, 32'h80000000, 32'h00000000,
              32'hFFFFFFF9};

    reset = 1'b1; start = 1'b0; op = ALU_ADD; a = 32'h0; b = 32'h0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), v_op[i], v_a[i], v_b[i], v_res[i]);

    // Non M-extension op is ignored
    start = 1'b1; op = ALU_ADD; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("add busy", {31'b0, busy}, 32'd0);
      chk("add done", {31'b0, done}, 32'd0);
      chk("add result", result, 32'hFFFFFFF9);
    end

    // start held high through the whole operation, with op/operands changing
    begin
      int n;
      bit got;
      start = 1'b1; op = ALU_DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1 op = ALU_MUL; a = 32'd3; b = 32'd5;
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (done === 1'b1) got = 1'b1;
      end
      chk("hold latency", n, XLEN + 2);
      chk("hold result", result, 32'd14);
      @(negedge clk);
      start = 1'b0;
      chk("hold no rerun busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("hold idle busy", {31'b0, busy}, 32'd0);
      chk("hold keep result", result, 32'd14);
    end

    // Reset in cycle 10 of a div, with a start colliding with reset
    start = 1'b1; op = ALU_DIV; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    reset = 1'b1; start = 1'b1; op = ALU_MUL; a = 32'd3; b = 32'd5;
    @(negedge clk);
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset result", result, 32'h0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("postreset idle", {31'b0, busy}, 32'd0);
    run_op("mul3x5", ALU_MUL, 32'd3, 32'd5, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
